rv32_regfile_mp: RTL and testbench



---
 rtl/rv32_regfile_mp.sv | 113 +++++++++++
 tb/tb_rv32_regfile_mp.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rv32_regfile_mp.sv
// rv32_regfile_mp: parametrised multi-read-port integer register file.
// Read addresses are captured on clk (held while stall_in=1). Data is read
// asynchronously from the captured address, so a write that commits on a
// capture edge, or while the address is held, is visible the next cycle.
// Optional feature macro: REGS_INIT_CLEAR_EN adds an INIT/READY sequencer
// that zeroes x1..x(NUM_REGS-1) after reset.
module rv32_regfile_mp #(
  parameter  int unsigned XLEN       = 32,
  parameter  int unsigned NUM_REGS   = 32,
  parameter  int unsigned READ_PORTS = 2,
  localparam int unsigned ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         stall_in,
  input  logic                         writeback_flush_in,
  input  logic [READ_PORTS*ADDR_W-1:0] rs_in,
  input  logic [ADDR_W-1:0]            rd_in,
  input  logic                         rd_write_in,
  input  logic [XLEN-1:0]              rd_value_in,
  output logic [READ_PORTS*XLEN-1:0]   rs_value_out,
  output logic                         init_busy_out
);

  typedef logic [ADDR_W-1:0] addr_t;

  // Packed so that port p occupies bits [p*ADDR_W +: ADDR_W], matching rs_in.
  addr_t [READ_PORTS-1:0] addr_q;
  addr_t [READ_PORTS-1:0] addr_d;

  logic              wr_en;
  addr_t             wr_addr;
  logic [XLEN-1:0]   wr_data;

`ifdef REGS_INIT_CLEAR_EN
  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e state_q;
  addr_t  clr_cnt_q;
  logic   busy_q;

  // Clear sequencer: walk x1..x(NUM_REGS-1); terminal compare avoids counter wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= addr_t'(1);
      busy_q    <= 1'b1;
    end else if (state_q == ST_INIT) begin
      if (clr_cnt_q == addr_t'(NUM_REGS - 1)) begin
        state_q <= ST_READY;
        busy_q  <= 1'b0;
      end else begin
        clr_cnt_q <= clr_cnt_q + addr_t'(1);
      end
    end else begin
      state_q <= ST_READY;
      busy_q  <= 1'b0;
    end
  end

  assign init_busy_out = busy_q;
`else
  assign init_busy_out = 1'b0;
`endif

  // Single write port shared by writeback and the clear sequencer.
  always_comb begin
    wr_en   = rd_write_in & ~writeback_flush_in & (rd_in != '0) & ~init_busy_out;
    wr_addr = rd_in;
    wr_data = rd_value_in;
`ifdef REGS_INIT_CLEAR_EN
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt_q;
      wr_data = '0;
    end
`endif
  end

  // Next captured read addresses: hold on stall, otherwise take rs_in.
  always_comb begin
    addr_d = addr_q;
    if (!stall_in) begin
      addr_d = rs_in;
    end
  end

  // Captured read address registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Storage is replicated per read port so each copy has one write and one
  // read port; reading from the captured address provides both bypass cases.
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [XLEN-1:0] mem [NUM_REGS];

    // Register array copy for this read port.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
    end

    assign rs_value_out[p*XLEN +: XLEN] =
      (init_busy_out || (addr_q[p] == '0)) ? '0 : mem[addr_q[p]];
  end

endmodule

// File: tb/tb_rv32_regfile_mp.sv
// Testbench for rv32_regfile_mp: directed vectors, a behavioural register
// model checked every cycle, plus hand-computed literal expectations.
module tb_rv32_regfile_mp;
  localparam int unsigned XL  = 32;
  localparam int unsigned NR  = 32;
  localparam int unsigned RP  = 4;
  localparam int unsigned AW  = 5;
  localparam int unsigned NR2 = 16;
  localparam int unsigned AW2 = 4;
`ifdef REGS_INIT_CLEAR_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, stall, flush, wr;
  logic [RP*AW-1:0]  rs;
  logic [AW-1:0]     rd;
  logic [XL-1:0]     val;
  logic [RP*XL-1:0]  rv;
  logic              busy;

  logic              rst2_n, wr2;
  logic [AW2-1:0]    rs2, rd2;
  logic [XL-1:0]     val2, rv2;
  logic              busy2;

  int n_cmp = 0;
  int n_bad = 0;

  rv32_regfile_mp #(.XLEN(XL), .NUM_REGS(NR), .READ_PORTS(RP)) u_dut (
    .clk(clk), .reset_n(rst_n), .stall_in(stall), .writeback_flush_in(flush),
    .rs_in(rs), .rd_in(rd), .rd_write_in(wr), .rd_value_in(val),
    .rs_value_out(rv), .init_busy_out(busy)
  );

  rv32_regfile_mp #(.XLEN(XL), .NUM_REGS(NR2), .READ_PORTS(1)) u_dut16 (
    .clk(clk), .reset_n(rst2_n), .stall_in(1'b0), .writeback_flush_in(1'b0),
    .rs_in(rs2), .rd_in(rd2), .rd_write_in(wr2), .rd_value_in(val2),
    .rs_value_out(rv2), .init_busy_out(busy2)
  );

  task automatic check(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [RP*AW-1:0] pack(input int a0, input int a1, input int a2, input int a3);
    logic [RP*AW-1:0] v;
    v = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    return v;
  endfunction

  // Behavioural model: architectural register contents, captured addresses,
  // and remaining clear-sequence cycles.
  logic [XL-1:0] m_mem   [NR];
  bit            m_known [NR];
  int unsigned   m_addr  [RP];
  int            m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < RP; p++) m_addr[p] = 0;
      m_busy = INIT_EN ? NR - 1 : 0;
      if (INIT_EN) begin
        for (int r = 0; r < NR; r++) begin
          m_mem[r]   = '0;
          m_known[r] = 1'b1;
        end
      end
    end else begin
      if (wr && !flush && rd != 0 && m_busy == 0) begin
        m_mem[rd]   = val;
        m_known[rd] = 1'b1;
      end
      if (!stall) begin
        for (int p = 0; p < RP; p++) m_addr[p] = rs[p*AW +: AW];
      end
      if (m_busy > 0) m_busy--;
    end
  end

  // Every-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    check("init_busy", XL'(busy), XL'(m_busy > 0));
    for (int p = 0; p < RP; p++) begin
      if (m_addr[p] == 0 || m_busy > 0)
        check($sformatf("port%0d", p), rv[p*XL +: XL], '0);
      else if (m_known[m_addr[p]])
        check($sformatf("port%0d", p), rv[p*XL +: XL], m_mem[m_addr[p]]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; wr = 1'b0;
    rs = '0; rd = '0; val = '0;
    rst2_n = 1'b0; wr2 = 1'b0; rs2 = '0; rd2 = '0; val2 = '0;
    repeat (2) step();
    check("reset_port0", rv[31:0], 32'h0);
    check("reset_busy", XL'(busy), XL'(INIT_EN));

    // Init clear: write to x5 right after release must be ignored while busy.
    rst_n = 1'b1;
    wr = 1'b1; rd = 5'd5; val = 32'hDEADBEEF;
    step();
    wr = 1'b0;
    n = 1;
    while (busy && n < 200) begin step(); n++; end
    check("init_len", n, INIT_EN ? 31 : 1);
    rs = pack(5, 0, 0, 0);
    step();
    check("x5_after_init", rv[31:0], INIT_EN ? 32'h0 : 32'hDEADBEEF);

    // Basic read.
    wr = 1'b1; rd = 5'd3; val = 32'h12345678; step();
    rd = 5'd4; val = 32'hCAFEF00D; step();
    wr = 1'b0; rs = pack(3, 4, 0, 0); step();
    check("basic_p0", rv[31:0], 32'h12345678);
    check("basic_p1", rv[63:32], 32'hCAFEF00D);

    // Same-edge bypass.
    wr = 1'b1; rd = 5'd7; val = 32'h1; step();
    rs = pack(7, 0, 0, 0); val = 32'hA5A5A5A5; step();
    wr = 1'b0;
    check("same_edge_p0", rv[31:0], 32'hA5A5A5A5);

    // Stall bypass, then flushed write.
    wr = 1'b1; rd = 5'd9; val = 32'h11; rs = pack(9, 9, 0, 0); step();
    check("pre_stall_p0", rv[31:0], 32'h11);
    stall = 1'b1; rs = pack(1, 1, 1, 1); val = 32'h55; step();
    check("stall_p0", rv[31:0], 32'h55);
    check("stall_p1", rv[63:32], 32'h55);
    flush = 1'b1; val = 32'h66; step();
    check("flush_p0", rv[31:0], 32'h55);
    flush = 1'b0; wr = 1'b0; stall = 1'b0;

    // x0 writes dropped; duplicate addresses see identical data.
    wr = 1'b1; rd = 5'd0; val = 32'hFFFFFFFF; rs = pack(0, 0, 0, 0); step();
    wr = 1'b0; step();
    for (int p = 0; p < RP; p++) check($sformatf("x0_p%0d", p), rv[p*XL +: XL], 32'h0);
    wr = 1'b1; rd = 5'd12; val = 32'h42; step();
    wr = 1'b0; rs = pack(12, 12, 12, 12); step();
    for (int p = 0; p < RP; p++) check($sformatf("dup_p%0d", p), rv[p*XL +: XL], 32'h42);

    // Asynchronous reset mid-cycle clears outputs immediately.
    #2 rst_n = 1'b0;
    #1;
    for (int p = 0; p < RP; p++) check($sformatf("async_rst_p%0d", p), rv[p*XL +: XL], 32'h0);
    check("async_rst_busy", XL'(busy), XL'(INIT_EN));
    step();
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 200) begin step(); n++; end
    check("reinit_len", n, INIT_EN ? 31 : 0);

    // Mid-init reset on the 16-entry instance.
    rst2_n = 1'b1;
    repeat (8) step();
    rst2_n = 1'b0;
    step();
    rst2_n = 1'b1;
    n = 0;
    while (busy2 && n < 200) begin step(); n++; end
    check("mid_init_len", n, INIT_EN ? 15 : 0);
`ifdef REGS_INIT_CLEAR_EN
    for (int r = 0; r < NR2; r++) begin
      rs2 = AW2'(r);
      step();
      check($sformatf("clr16_x%0d", r), rv2, 32'h0);
    end
`endif
    wr2 = 1'b1; rd2 = 4'd3; val2 = 32'h77; rs2 = 4'd3; step();
    wr2 = 1'b0;
    check("r16_x3", rv2, 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
